// File: rtl/register_lanes_if.sv
// Serial lane-fill stream: one W-bit lane per valid/ready beat, s_last ends a burst early.
interface register_lanes_if #(
  parameter int unsigned W = 8
);
  logic         s_valid;
  logic [W-1:0] s_data;
  logic         s_last;
  logic         s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/register_lanes.sv
// Lane register with per-lane parallel loads and a serial fill path that stages
// lanes and commits them to out atomically in one cycle.
module register_lanes #(
  parameter  int unsigned W     = 8,
  parameter  int unsigned LANES = 2,
  localparam int unsigned PW    = $clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 clear_n,
  input  logic                 sync_clear,
  input  logic [W*LANES-1:0]   in_data,
  input  logic [LANES-1:0]     load,
  register_lanes_if.slave      s,
  output logic [W*LANES-1:0]   out,
  output logic [PW-1:0]        ptr,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     stage [LANES];
  logic [LANES-1:0] mask;
  logic             accept;
  logic             last_beat;
  logic             commit;

  assign accept    = s.s_valid & s.s_ready;
  assign last_beat = (ptr == PW'(LANES - 1)) | s.s_last;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)        state <= IDLE;
    else if (sync_clear) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = FILL;
      FILL:    if (accept && last_beat) state_nxt = COMMIT;
      COMMIT:  state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  // s_ready is a pure decode of the registered state.
  always_comb begin
    s.s_ready = 1'b0;
    commit    = 1'b0;
    unique case (state)
      FILL:    s.s_ready = 1'b1;
      COMMIT:  commit    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ptr  <= '0;
      mask <= '0;
      for (int unsigned i = 0; i < LANES; i++) stage[i] <= '0;
    end else if (sync_clear) begin
      ptr  <= '0;
      mask <= '0;
      for (int unsigned i = 0; i < LANES; i++) stage[i] <= '0;
    end else begin
      if (accept) begin
        stage[ptr] <= s.s_data;
        mask[ptr]  <= 1'b1;
        ptr        <= last_beat ? '0 : ptr + PW'(1);
      end
      if (commit) mask <= '0;
    end
  end

  // Parallel load takes priority over a commit of the same lane.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      out  <= '0;
      done <= 1'b0;
    end else if (sync_clear) begin
      out  <= '0;
      done <= 1'b0;
    end else begin
      done <= commit;
      for (int unsigned i = 0; i < LANES; i++) begin
        if (load[i])                out[i*W +: W] <= in_data[i*W +: W];
        else if (commit && mask[i]) out[i*W +: W] <= stage[i];
      end
    end
  end

endmodule

// File: tb/tb_register_lanes.sv
// Directed bench for register_lanes (LANES=4 and LANES=3) with a burst-level reference model.
module tb_register_lanes;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        sync_clear = 1'b0;
  logic [31:0] in4 = '0;
  logic [3:0]  load4 = '0;
  logic [23:0] in3 = '0;
  logic [2:0]  load3 = '0;
  logic [31:0] out4;
  logic [23:0] out3;
  logic [1:0]  ptr4, ptr3;
  logic        done4, done3;

  int errors = 0;
  int checks = 0;

  register_lanes_if #(.W(8)) bus4 ();
  register_lanes_if #(.W(8)) bus3 ();

  register_lanes #(.W(8), .LANES(4)) dut4 (
    .clk(clk), .clear_n(clear_n), .sync_clear(sync_clear),
    .in_data(in4), .load(load4), .s(bus4.slave),
    .out(out4), .ptr(ptr4), .done(done4)
  );

  register_lanes #(.W(8), .LANES(3)) dut3 (
    .clk(clk), .clear_n(clear_n), .sync_clear(sync_clear),
    .in_data(in3), .load(load3), .s(bus3.slave),
    .out(out3), .ptr(ptr3), .done(done3)
  );

  always #5 clk = ~clk;

  // Burst-level model: staged beats are a count plus a list, commit is a pending flag.
  typedef struct {
    logic [7:0] o  [4];
    logic [7:0] st [4];
    int         cnt;
    bit         ready;
    bit         cmt;
    bit         done;
  } mdl_t;

  mdl_t m4, m3;

  function automatic mdl_t mreset();
    mdl_t r;
    for (int i = 0; i < 4; i++) begin
      r.o[i]  = '0;
      r.st[i] = '0;
    end
    r.cnt = 0; r.ready = 0; r.cmt = 0; r.done = 0;
    return r;
  endfunction

  function automatic logic [31:0] mpack(input mdl_t m, input int lanes);
    logic [31:0] r = '0;
    for (int i = 0; i < lanes; i++) r[i*8 +: 8] = m.o[i];
    return r;
  endfunction

  task automatic mstep(inout mdl_t m, input int lanes, input logic sc,
                       input logic [31:0] ind, input logic [3:0] ld,
                       input logic v, input logic [7:0] d, input logic lst);
    bit nd;
    if (sc) begin
      m = mreset();
      return;
    end
    nd = m.cmt;
    for (int i = 0; i < lanes; i++) begin
      if (ld[i])                   m.o[i] = ind[i*8 +: 8];
      else if (m.cmt && i < m.cnt) m.o[i] = m.st[i];
    end
    if (m.cmt) begin
      m.cnt = 0; m.cmt = 0; m.ready = 1;
    end else if (!m.ready) begin
      m.ready = 1;
    end else if (v) begin
      m.st[m.cnt] = d;
      m.cnt++;
      if (m.cnt == lanes || lst) begin
        m.cmt = 1; m.ready = 0;
      end
    end
    m.done = nd;
  endtask

  always @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      m4 = mreset();
      m3 = mreset();
    end else begin
      mstep(m4, 4, sync_clear, in4, load4, bus4.s_valid, bus4.s_data, bus4.s_last);
      mstep(m3, 3, sync_clear, {8'h00, in3}, {1'b0, load3}, bus3.s_valid, bus3.s_data, bus3.s_last);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    check("m4.out",   out4,            mpack(m4, 4));
    check("m4.ready", 32'(bus4.s_ready), 32'(m4.ready));
    check("m4.done",  32'(done4),      32'(m4.done));
    check("m4.ptr",   32'(ptr4),       m4.cmt ? 32'd0 : 32'(m4.cnt));
    check("m3.out",   32'(out3),       mpack(m3, 3));
    check("m3.ready", 32'(bus3.s_ready), 32'(m3.ready));
    check("m3.done",  32'(done3),      32'(m3.done));
    check("m3.ptr",   32'(ptr3),       m3.cmt ? 32'd0 : 32'(m3.cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat4(input logic v, input logic [7:0] d, input logic lst);
    bus4.s_valid = v; bus4.s_data = d; bus4.s_last = lst;
  endtask

  task automatic beat3(input logic v, input logic [7:0] d);
    bus3.s_valid = v; bus3.s_data = d; bus3.s_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat4(0, 8'h00, 0);
    beat3(0, 8'h00);
    tick(); tick();
    check("rst.out",   out4, 32'h0);
    check("rst.ready", 32'(bus4.s_ready), 32'h0);
    check("rst.done",  32'(done4), 32'h0);
    check("rst.ptr",   32'(ptr4), 32'h0);
    clear_n = 1'b1;
    tick();
    check("rel.ready", 32'(bus4.s_ready), 32'h1);

    // parallel loads
    load4 = 4'b0101; in4 = 32'hAABBCCDD;
    tick();
    check("pl.0101", out4, 32'h00BB00DD);
    load4 = 4'b1000;
    tick();
    check("pl.1000", out4, 32'hAABB00DD);
    load4 = '0;

    // full serial burst
    beat4(1, 8'h11, 0); tick(); check("fb.ptr1", 32'(ptr4), 32'd1);
    beat4(1, 8'h22, 0); tick(); check("fb.ptr2", 32'(ptr4), 32'd2);
    beat4(1, 8'h33, 0); tick(); check("fb.ptr3", 32'(ptr4), 32'd3);
    beat4(1, 8'h44, 0); tick();
    check("fb.bubble", 32'(bus4.s_ready), 32'h0);
    check("fb.hold", out4, 32'hAABB00DD);
    beat4(0, 8'h00, 0); tick();
    check("fb.out", out4, 32'h44332211);
    check("fb.done", 32'(done4), 32'h1);
    check("fb.ready", 32'(bus4.s_ready), 32'h1);
    tick();
    check("fb.done0", 32'(done4), 32'h0);

    // partial burst with gap, beat offered during COMMIT
    beat4(1, 8'h55, 0); tick();
    beat4(0, 8'h00, 0); tick();
    beat4(1, 8'h66, 1); tick();
    beat4(1, 8'h99, 0); tick();
    check("pb.out", out4, 32'h44336655);
    check("pb.done", 32'(done4), 32'h1);
    check("pb.noconsume", 32'(ptr4), 32'd0);
    beat4(0, 8'h00, 0); tick();

    // collision: load lane 1 on the commit edge
    beat4(1, 8'h55, 0); tick();
    beat4(1, 8'h66, 1); tick();
    beat4(0, 8'h00, 0); load4 = 4'b0010; in4 = 32'h00007700;
    tick();
    check("col.out", out4, 32'h44337755);
    load4 = '0;

    // async reset mid-burst
    beat4(1, 8'hAA, 0); tick();
    beat4(1, 8'hBB, 0); tick();
    beat4(0, 8'h00, 0);
    #2 clear_n = 1'b0;
    #1;
    check("ar.out", out4, 32'h0);
    check("ar.ptr", 32'(ptr4), 32'h0);
    tick();
    clear_n = 1'b1;
    tick();
    beat4(1, 8'hC1, 1); tick();
    beat4(0, 8'h00, 0); tick();
    check("ar.own", out4, 32'h000000C1);
    check("ar.done", 32'(done4), 32'h1);

    // sync_clear during COMMIT also overrides loads
    beat4(1, 8'hD1, 0); tick();
    beat4(1, 8'hD2, 1); tick();
    beat4(0, 8'h00, 0); sync_clear = 1'b1; load4 = 4'hF; in4 = 32'hFFFFFFFF;
    tick();
    sync_clear = 1'b0; load4 = '0;
    check("sc.out", out4, 32'h0);
    check("sc.done", 32'(done4), 32'h0);
    check("sc.ready", 32'(bus4.s_ready), 32'h0);
    tick();
    check("sc.done1", 32'(done4), 32'h0);
    check("sc.ready1", 32'(bus4.s_ready), 32'h1);

    // LANES=3: pointer wraps 2 -> 0
    check("l3.ptr0", 32'(ptr3), 32'd0);
    beat3(1, 8'h01); tick(); check("l3.ptr1", 32'(ptr3), 32'd1);
    beat3(1, 8'h02); tick(); check("l3.ptr2", 32'(ptr3), 32'd2);
    beat3(1, 8'h03); tick(); check("l3.wrap", 32'(ptr3), 32'd0);
    beat3(0, 8'h00); tick();
    check("l3.out", 32'(out3), 32'h00030201);
    check("l3.done", 32'(done3), 32'h1);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
